// File: rtl/mips_mem_pkg.sv
// Shared encodings for the MEM stage: access sizes, FSM states, byte-lane masks.
package mips_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // Half needs addr[0]==0, word (and the 11 alias) needs addr[1:0]==0.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr_lo[0];
      default: bad = (addr_lo != 2'b00);
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/half out of a little-endian read word and extends it to 32 bits.
module load_align
  import mips_mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] data
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  // Lane select followed by sign or zero extension.
  always_comb begin
    byte_val = rdata[8*addr_lo +: 8];
    half_val = rdata[16*addr_lo[1] +: 16];
    case (size)
      SZ_BYTE: data = is_unsigned ? {24'd0, byte_val} : {{24{byte_val[7]}}, byte_val};
      SZ_HALF: data = is_unsigned ? {16'd0, half_val} : {{16{half_val[15]}}, half_val};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: issues one load/store at a time over a req/ack port, stalls upstream while
// an access is outstanding, and loads the MEM/WB register for the write-back mux.
//
// Handshake: dmem_req rises the cycle after a memory op is accepted and, together with
// dmem_we/addr/wdata/be, is held constant until the cycle in which dmem_ack=1. That cycle
// completes the access (rdata is valid then); req falls on the following edge. dmem_ack
// is ignored whenever no request is outstanding.
module mem_access_stage
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_mem_to_reg,
  input  logic              ex_reg_write,
  input  logic [1:0]        ex_size,
  input  logic              ex_unsigned,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [4:0]        ex_rd,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic [3:0]        dmem_be,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [ADDR_W-1:0] wb_alu,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_mem_to_reg,
  output logic              wb_reg_write,
  output logic [4:0]        wb_rd,
  output logic              misalign,
  output state_t            fsm_state
);

  state_t            state;
  logic [ADDR_W-1:0] lat_addr;
  logic [1:0]        lat_size;
  logic              lat_unsigned;
  logic              lat_we;
  logic              lat_mem_to_reg;
  logic              lat_reg_write;
  logic [4:0]        lat_rd;

  logic              is_mem;
  logic              bad_align;
  logic              accept;
  logic [DATA_W-1:0] wdata_next;
  logic [3:0]        be_next;
  logic [DATA_W-1:0] load_data;

  assign fsm_state = state;

  // Accept / stall decision; stall drops in the ack cycle so upstream can advance.
  always_comb begin
    is_mem    = ex_mem_read | ex_mem_write;
    bad_align = is_misaligned(ex_size, ex_addr[1:0]);
    accept    = (state == ST_IDLE) && ex_valid && is_mem && !bad_align;
    stall     = accept || ((state == ST_WAIT) && !dmem_ack);
  end

  // Store lane replication and byte enables; loads always read the whole word.
  always_comb begin
    case (ex_size)
      SZ_BYTE: begin
        wdata_next = {4{ex_store_data[7:0]}};
        be_next    = BE_BYTE << ex_addr[1:0];
      end
      SZ_HALF: begin
        wdata_next = {2{ex_store_data[15:0]}};
        be_next    = BE_HALF << ex_addr[1:0];
      end
      default: begin
        wdata_next = ex_store_data;
        be_next    = BE_WORD;
      end
    endcase
    if (!ex_mem_write) be_next = BE_WORD;
  end

  load_align u_load_align (
    .rdata       (dmem_rdata),
    .addr_lo     (lat_addr[1:0]),
    .size        (lat_size),
    .is_unsigned (lat_unsigned),
    .data        (load_data)
  );

  // FSM, memory-port registers and MEM/WB register; a bubble is loaded whenever
  // nothing completes on an edge so no instruction is written back twice.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      lat_addr       <= '0;
      lat_size       <= SZ_BYTE;
      lat_unsigned   <= 1'b0;
      lat_we         <= 1'b0;
      lat_mem_to_reg <= 1'b0;
      lat_reg_write  <= 1'b0;
      lat_rd         <= '0;
      dmem_req       <= 1'b0;
      dmem_we        <= 1'b0;
      dmem_addr      <= '0;
      dmem_wdata     <= '0;
      dmem_be        <= '0;
      wb_alu         <= '0;
      wb_data        <= '0;
      wb_mem_to_reg  <= 1'b0;
      wb_reg_write   <= 1'b0;
      wb_rd          <= '0;
      misalign       <= 1'b0;
    end else begin
      misalign      <= 1'b0;
      wb_alu        <= '0;
      wb_data       <= '0;
      wb_mem_to_reg <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_rd         <= '0;
      case (state)
        ST_IDLE: begin
          if (ex_valid && is_mem) begin
            if (bad_align) begin
              misalign <= 1'b1;
            end else begin
              lat_addr       <= ex_addr;
              lat_size       <= ex_size;
              lat_unsigned   <= ex_unsigned;
              lat_we         <= ex_mem_write;
              lat_mem_to_reg <= ex_mem_to_reg;
              lat_reg_write  <= ex_reg_write;
              lat_rd         <= ex_rd;
              dmem_req       <= 1'b1;
              dmem_we        <= ex_mem_write;
              dmem_addr      <= {ex_addr[ADDR_W-1:2], 2'b00};
              dmem_wdata     <= wdata_next;
              dmem_be        <= be_next;
              state          <= ST_WAIT;
            end
          end else if (ex_valid) begin
            wb_alu        <= ex_addr;
            wb_mem_to_reg <= ex_mem_to_reg;
            wb_reg_write  <= ex_reg_write && (ex_rd != 5'd0);
            wb_rd         <= ex_rd;
          end
        end
        ST_WAIT: begin
          if (dmem_ack) begin
            dmem_req      <= 1'b0;
            state         <= ST_IDLE;
            wb_alu        <= lat_addr;
            wb_data       <= lat_we ? '0 : load_data;
            wb_mem_to_reg <= lat_mem_to_reg;
            wb_reg_write  <= lat_reg_write && (lat_rd != 5'd0);
            wb_rd         <= lat_rd;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a MEM/WB scoreboard queue.
module tb_mem_access_stage;
  import mips_mem_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_mem_to_reg;
  logic        ex_reg_write;
  logic [1:0]  ex_size;
  logic        ex_unsigned;
  logic [31:0] ex_addr;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_rd;
  logic        stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic [31:0] wb_alu;
  logic [31:0] wb_data;
  logic        wb_mem_to_reg;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic        misalign;
  state_t      fsm_state;

  int errors = 0;
  int checks = 0;
  logic [70:0] exp_q[$];

  mem_access_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ex_valid      (ex_valid),
    .ex_mem_read   (ex_mem_read),
    .ex_mem_write  (ex_mem_write),
    .ex_mem_to_reg (ex_mem_to_reg),
    .ex_reg_write  (ex_reg_write),
    .ex_size       (ex_size),
    .ex_unsigned   (ex_unsigned),
    .ex_addr       (ex_addr),
    .ex_store_data (ex_store_data),
    .ex_rd         (ex_rd),
    .stall         (stall),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_be       (dmem_be),
    .dmem_ack      (dmem_ack),
    .dmem_rdata    (dmem_rdata),
    .wb_alu        (wb_alu),
    .wb_data       (wb_data),
    .wb_mem_to_reg (wb_mem_to_reg),
    .wb_reg_write  (wb_reg_write),
    .wb_rd         (wb_rd),
    .misalign      (misalign),
    .fsm_state     (fsm_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [70:0] obs, input logic [70:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [70:0] wb_pack(input logic [31:0] alu, input logic [31:0] data,
                                          input logic m2r, input logic rw, input logic [4:0] rd);
    return {alu, data, m2r, rw, rd};
  endfunction

  task automatic pop_wb(input string tag);
    logic [70:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: scoreboard empty, got %0h", tag,
             wb_pack(wb_alu, wb_data, wb_mem_to_reg, wb_reg_write, wb_rd));
    end else begin
      e = exp_q.pop_front();
      chk(tag, wb_pack(wb_alu, wb_data, wb_mem_to_reg, wb_reg_write, wb_rd), e);
    end
  endtask

  // Driver helpers: all called at posedge+1, return at posedge+1.
  task automatic idle_inputs();
    ex_valid = 0; ex_mem_read = 0; ex_mem_write = 0; ex_mem_to_reg = 0;
    ex_reg_write = 0; ex_size = SZ_WORD; ex_unsigned = 0; ex_addr = '0;
    ex_store_data = '0; ex_rd = '0;
  endtask

  task automatic do_alu(input string tag, input logic [31:0] addr, input logic [4:0] rd,
                        input logic rw);
    ex_valid = 1; ex_mem_read = 0; ex_mem_write = 0; ex_mem_to_reg = 0;
    ex_reg_write = rw; ex_addr = addr; ex_rd = rd;
    exp_q.push_back(wb_pack(addr, 32'd0, 1'b0, rw && (rd != 0), rd));
    #3 chk({tag, "_stall"}, stall, 1'b0);
    @(posedge clk); #1;
    idle_inputs();
    pop_wb(tag);
  endtask

  task automatic do_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [4:0] rd, input logic [31:0] rdata,
                         input logic [31:0] exp_data, input int waits);
    ex_valid = 1; ex_mem_read = 1; ex_mem_write = 0; ex_mem_to_reg = 1;
    ex_reg_write = 1; ex_size = size; ex_unsigned = uns; ex_addr = addr; ex_rd = rd;
    exp_q.push_back(wb_pack(addr, exp_data, 1'b1, rd != 0, rd));
    #3 chk({tag, "_acc_stall"}, stall, 1'b1);
    @(posedge clk); #1;
    chk({tag, "_port"}, {dmem_req, dmem_we, dmem_addr, dmem_be},
        {1'b1, 1'b0, addr[31:2], 2'b00, 4'hF});
    for (int i = 0; i < waits; i++) begin
      #3 chk({tag, "_wait_stall"}, stall, 1'b1);
      @(posedge clk); #1;
    end
    dmem_ack = 1; dmem_rdata = rdata;
    #3 chk({tag, "_ack_stall"}, stall, 1'b0);
    @(posedge clk); #1;
    dmem_ack = 0; dmem_rdata = $urandom;
    idle_inputs();
    pop_wb(tag);
    chk({tag, "_req_drop"}, {dmem_req, fsm_state}, {1'b0, ST_IDLE});
  endtask

  task automatic do_store(input string tag, input logic [31:0] addr, input logic [1:0] size,
                          input logic [31:0] data, input logic [3:0] exp_be,
                          input logic [31:0] exp_wdata, input int waits);
    int stalls;
    stalls = 0;
    ex_valid = 1; ex_mem_read = 0; ex_mem_write = 1; ex_mem_to_reg = 0;
    ex_reg_write = 0; ex_size = size; ex_addr = addr; ex_store_data = data; ex_rd = 0;
    exp_q.push_back(wb_pack(addr, 32'd0, 1'b0, 1'b0, 5'd0));
    #3 if (stall) stalls++;
    @(posedge clk); #1;
    for (int i = 0; i < waits; i++) begin
      #3 if (stall) stalls++;
      chk({tag, "_port"}, {dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata},
          {1'b1, 1'b1, addr[31:2], 2'b00, exp_be, exp_wdata});
      @(posedge clk); #1;
    end
    dmem_ack = 1;
    #3 if (stall) stalls++;
    @(posedge clk); #1;
    dmem_ack = 0;
    idle_inputs();
    chk({tag, "_stall_cycles"}, stalls, waits + 1);
    pop_wb(tag);
  endtask

  initial begin
    dmem_ack = 0; dmem_rdata = '0;
    idle_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs",
        {dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, misalign, fsm_state},
        {1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0, ST_IDLE});
    chk("reset_wb", wb_pack(wb_alu, wb_data, wb_mem_to_reg, wb_reg_write, wb_rd), 71'd0);
    rst_n = 1;
    @(posedge clk); #1;

    do_alu("alu_1234", 32'h1234, 5'd5, 1'b1);
    do_alu("alu_rd0", 32'h55AA, 5'd0, 1'b1);
    for (int i = 0; i < 4; i++)
      do_alu("alu_rand", $urandom, 5'($urandom_range(1, 31)), 1'($urandom_range(0, 1)));

    // Invalid instruction with live-looking controls must become a bubble.
    ex_valid = 0; ex_reg_write = 1; ex_rd = 5'd9; ex_addr = 32'hFFFF; ex_mem_read = 1;
    dmem_ack = 1;
    exp_q.push_back(71'd0);
    #3 chk("idle_ack_stall", stall, 1'b0);
    @(posedge clk); #1;
    dmem_ack = 0;
    idle_inputs();
    pop_wb("bubble");
    chk("idle_ack_req", dmem_req, 1'b0);

    do_load("lb",  32'h103, SZ_BYTE, 1'b0, 5'd7, 32'h80FF_0000, 32'hFFFF_FF80, 0);
    do_load("lbu", 32'h103, SZ_BYTE, 1'b1, 5'd7, 32'h80FF_0000, 32'h0000_0080, 0);
    do_load("lh",  32'h102, SZ_HALF, 1'b0, 5'd8, 32'h8001_7FFF, 32'hFFFF_8001, 1);
    do_load("lhu", 32'h100, SZ_HALF, 1'b1, 5'd8, 32'h8001_F123, 32'h0000_F123, 2);
    do_load("lb1", 32'h201, SZ_BYTE, 1'b0, 5'd3, 32'h1234_7F56, 32'h0000_007F, 0);
    do_load("lw",  32'h104, SZ_WORD, 1'b0, 5'd9, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1);
    do_load("lw_rd0", 32'h108, SZ_WORD, 1'b0, 5'd0, 32'h1111_2222, 32'h1111_2222, 0);

    do_store("sb", 32'h101, SZ_BYTE, 32'h0000_00AB, 4'b0010, 32'hABAB_ABAB, 3);
    do_store("sh", 32'h102, SZ_HALF, 32'h5678_1234, 4'b1100, 32'h1234_1234, 1);
    do_store("sw", 32'h108, SZ_WORD, 32'hCAFE_F00D, 4'hF, 32'hCAFE_F00D, 1);

    // Misaligned word load: no request, one-cycle pulse, bubble.
    ex_valid = 1; ex_mem_read = 1; ex_mem_to_reg = 1; ex_reg_write = 1;
    ex_size = SZ_WORD; ex_addr = 32'h102; ex_rd = 5'd4;
    exp_q.push_back(71'd0);
    #3 chk("mis_stall", stall, 1'b0);
    @(posedge clk); #1;
    idle_inputs();
    chk("mis_pulse", {misalign, dmem_req}, 2'b10);
    pop_wb("mis_wb");
    #3;
    @(posedge clk); #1;
    chk("mis_pulse_end", {misalign, dmem_req}, 2'b00);

    // Reset while waiting for ack, then a late ack that must be ignored.
    ex_valid = 1; ex_mem_read = 1; ex_mem_to_reg = 1; ex_reg_write = 1;
    ex_size = SZ_WORD; ex_addr = 32'h300; ex_rd = 5'd6;
    @(posedge clk); #1;
    chk("rst_wait_req", dmem_req, 1'b1);
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    idle_inputs();
    chk("rst_wait_state", {dmem_req, fsm_state, misalign}, {1'b0, ST_IDLE, 1'b0});
    dmem_ack = 1; dmem_rdata = 32'h7777_7777;
    #3 chk("late_ack_stall", stall, 1'b0);
    @(posedge clk); #1;
    dmem_ack = 0;
    chk("late_ack_wb", wb_pack(wb_alu, wb_data, wb_mem_to_reg, wb_reg_write, wb_rd), 71'd0);
    chk("late_ack_req", dmem_req, 1'b0);

    do_alu("alu_after_rst", 32'hA5A5, 5'd31, 1'b1);
    chk("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
